// File: rtl/param_arb_pkg.sv
// Shared types for the parameter ROM stream arbiter.
// Tag carried alongside ROM reads, FIFO entry, round-robin helper.
package param_arb_pkg;

  localparam int ARB_NUM_REQ    = 4;
  localparam int ARB_DATA_WIDTH = 32;
  localparam int ARB_ID_W       = $clog2(ARB_NUM_REQ);

  typedef struct packed {
    logic                valid;
    logic [ARB_ID_W-1:0] id;
  } tag_t;

  typedef struct packed {
    logic [ARB_DATA_WIDTH-1:0] data;
    logic                      last;
  } fifo_entry_t;

  function automatic logic [ARB_ID_W-1:0] rr_next(
    input logic [ARB_ID_W-1:0] id,
    input int                  n
  );
    return (int'(id) == n - 1) ? '0 : id + ARB_ID_W'(1);
  endfunction

endpackage

// File: rtl/param_rom_stream_arbiter_if.sv
// Per-requester stream bundle: enables, data, valid/ready, pass pulse.
// slave = arbiter side, master = consumer side.
interface param_rom_stream_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_REQ-1:0]                 req_en;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_out;
  logic [NUM_REQ-1:0]                 data_out_valid;
  logic [NUM_REQ-1:0]                 data_out_ready;
  logic [NUM_REQ-1:0]                 pass_done;

  modport slave (
    input  req_en,
    input  data_out_ready,
    output data_out,
    output data_out_valid,
    output pass_done
  );

  modport master (
    output req_en,
    output data_out_ready,
    input  data_out,
    input  data_out_valid,
    input  pass_done
  );

endinterface

// File: rtl/param_arb_fifo.sv
// Small synchronous FIFO with occupancy count.
// Push and pop in the same cycle leave the count unchanged.
module param_arb_fifo
  import param_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output fifo_entry_t dout,
  output logic [CW-1:0] count
);

  fifo_entry_t   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign full  = (int'(count) == DEPTH);
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && full && !pop));
      assert (!(pop && empty));
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/param_rom_stream_arbiter.sv
// Round-robin sharing of one fixed-latency ROM among NUM_REQ wrapping streams.
// Define PARAM_ARB_STATS_EN to add the per-requester grant_count port.
module param_rom_stream_arbiter
  import param_arb_pkg::*;
#(
  parameter int NUM_REQ     = ARB_NUM_REQ,
  parameter int DATA_WIDTH  = ARB_DATA_WIDTH,
  parameter int REQ_DEPTH   = 24,
  parameter int ROM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_WIDTH  = $clog2(NUM_REQ * REQ_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
`ifdef PARAM_ARB_STATS_EN
  output logic [NUM_REQ-1:0][31:0] grant_count,
`endif
  param_rom_stream_arbiter_if.slave stream
);

  localparam int ID_W  = ARB_ID_W;
  localparam int CNT_W = $clog2(REQ_DEPTH);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int IW    = $clog2(ROM_LATENCY + 1);

  logic [NUM_REQ-1:0][CNT_W-1:0] cnt;
  logic [NUM_REQ-1:0][CNT_W-1:0] land_cnt;
  logic [NUM_REQ-1:0][CW-1:0]    fifo_count;
  logic [NUM_REQ-1:0][IW-1:0]    inflight;
  logic [NUM_REQ-1:0]            eligible;
  logic [NUM_REQ-1:0]            push;
  logic [NUM_REQ-1:0]            pop;
  logic [NUM_REQ-1:0]            valid;
  logic [NUM_REQ-1:0]            pdone;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] dout;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_id;
  logic            gnt;

  tag_t        tag_pipe [ROM_LATENCY];
  tag_t        tag_in;
  tag_t        exit_tag;
  fifo_entry_t wr_entry;
  fifo_entry_t head [NUM_REQ];

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (int'(c) == REQ_DEPTH - 1) ? '0 : c + CNT_W'(1);
  endfunction

  // Every tag still in the pipe holds a FIFO slot in reserve.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int s = 0; s < ROM_LATENCY; s++) begin
        if (tag_pipe[s].valid && int'(tag_pipe[s].id) == i)
          inflight[i] = inflight[i] + IW'(1);
      end
    end
  end

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible[i] = stream.req_en[i] &&
        ((int'(fifo_count[i]) + int'(inflight[i])) < FIFO_DEPTH);
    end
  end

  always_comb begin
    int idx;
    gnt    = 1'b0;
    gnt_id = rr_ptr;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!rst && !gnt && eligible[idx]) begin
        gnt    = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

  assign rom_ce   = 1'b1;
  assign rom_addr = gnt
    ? ADDR_WIDTH'(int'(gnt_id) * REQ_DEPTH + int'(cnt[gnt_id]))
    : '0;

  assign tag_in.valid = gnt;
  assign tag_in.id    = gnt_id;
  assign exit_tag     = tag_pipe[ROM_LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      cnt      <= '0;
      land_cnt <= '0;
      for (int s = 0; s < ROM_LATENCY; s++)
        tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int s = 1; s < ROM_LATENCY; s++)
        tag_pipe[s] <= tag_pipe[s-1];
      if (gnt) begin
        rr_ptr      <= rr_next(gnt_id, NUM_REQ);
        cnt[gnt_id] <= cnt_inc(cnt[gnt_id]);
      end
      if (exit_tag.valid)
        land_cnt[exit_tag.id] <= cnt_inc(land_cnt[exit_tag.id]);
    end
  end

  // Words land in issue order, so a landing counter recovers the element index.
  assign wr_entry.data = rom_q;
  assign wr_entry.last = (int'(land_cnt[exit_tag.id]) == REQ_DEPTH - 1);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign push[i]  = exit_tag.valid && (int'(exit_tag.id) == i);
    assign valid[i] = (fifo_count[i] != '0);
    assign pop[i]   = valid[i] && stream.data_out_ready[i];
    assign dout[i]  = valid[i] ? head[i].data : '0;
    assign pdone[i] = pop[i] && head[i].last;

    param_arb_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   (wr_entry),
      .pop   (pop[i]),
      .dout  (head[i]),
      .count (fifo_count[i])
    );
  end

  assign stream.data_out_valid = valid;
  assign stream.data_out       = dout;
  assign stream.pass_done      = pdone;

`ifdef PARAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      grant_count <= '0;
    else if (gnt)
      grant_count[gnt_id] <= grant_count[gnt_id] + 32'd1;
  end
`endif

endmodule
